// File: rtl/mext_issue_ctrl.sv
// Issue sequencer for the multi-cycle multiplier/divider wrappers: launches one unit,
// stalls execute until it reports done (or the watchdog fires), then holds the result.
//
//   state | meaning
//   IDLE  | no M-op in flight; accepts a new M-op from execute
//   BUSY  | start issued, waiting for the selected unit's done
//   HOLD  | result captured, waiting for downstream advance
module mext_issue_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex,
    input  logic            flush_ex,
    input  logic            m_op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            advance,
    output logic            mul_start,
    output logic            div_start,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    output logic [2:0]      unit_funct3,
    output logic            unit_flush,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_result,
    input  logic            div_done,
    input  logic [XLEN-1:0] div_result,
    output logic [XLEN-1:0] m_result,
    output logic            done_ex,
    output logic            stall_ex,
    output logic            timeout_err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_div_q, sel_div_d;
    logic            mul_start_q, mul_start_d;
    logic            div_start_q, div_start_d;
    logic [XLEN-1:0] unit_a_q, unit_a_d;
    logic [XLEN-1:0] unit_b_q, unit_b_d;
    logic [2:0]      unit_funct3_q, unit_funct3_d;
    logic [XLEN-1:0] m_result_q, m_result_d;
    logic            timeout_err_q, timeout_err_d;

    logic            accept;
    logic            sel_done;
    logic [XLEN-1:0] sel_result;

    assign accept     = valid_ex & m_op & ~flush_ex;
    // Only the launched unit is listened to; a stray done from the other is ignored.
    assign sel_done   = sel_div_q ? div_done : mul_done;
    assign sel_result = sel_div_q ? div_result : mul_result;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_div_d     = sel_div_q;
        mul_start_d   = 1'b0;
        div_start_d   = 1'b0;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        unit_funct3_d = unit_funct3_q;
        m_result_d    = m_result_q;
        timeout_err_d = timeout_err_q;

        if (flush_ex) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        unit_a_d      = op_a;
                        unit_b_d      = op_b;
                        unit_funct3_d = funct3;
                        sel_div_d     = funct3[2];
                        mul_start_d   = ~funct3[2];
                        div_start_d   = funct3[2];
                        cnt_d         = '0;
                        state_d       = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Done on the last watchdog cycle still counts as a normal completion.
                    if (sel_done) begin
                        m_result_d = sel_result;
                        state_d    = ST_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        m_result_d    = '0;
                        timeout_err_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sel_div_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            div_start_q   <= 1'b0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            unit_funct3_q <= '0;
            m_result_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_div_q     <= sel_div_d;
            mul_start_q   <= mul_start_d;
            div_start_q   <= div_start_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            unit_funct3_q <= unit_funct3_d;
            m_result_q    <= m_result_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mul_start   = mul_start_q;
    assign div_start   = div_start_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign unit_funct3 = unit_funct3_q;
    assign m_result    = m_result_q;
    assign timeout_err = timeout_err_q;
    assign unit_flush  = flush_ex;

    // Combinational so non-M instructions retire with no added latency.
    assign done_ex  = ~(valid_ex & m_op) | (state_q == ST_HOLD);
    assign stall_ex = valid_ex & m_op & ~done_ex;

endmodule
